ram_load_scheduler: RTL and testbench
=====================================

Name: ram_load_scheduler

Overview:
Owns the 16x8 program RAM's load port and sequences the CPU core around it. It accepts program bytes from a host over a valid/ready handshake and drives the RAM input_mode/input_address/input_program writes. It holds the CPU in reset while loading, releases it to run, and detects halt or a cycle-budget timeout. It replaces the open-loop bench loading with a checked controller.

Parameters:
ADDR_W, 4, RAM address width (16 locations)
DATA_W, 8, RAM word width (opcode nibble + operand nibble)
MAX_CYCLES, 255, RUN-state clock budget before forced stop
CNT_W, 8, run cycle counter width; must hold MAX_CYCLES

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
load_start  in  1  host request to begin (re)loading; sampled in IDLE/DONE only
load_valid  in  1  host byte valid
load_addr  in  ADDR_W  target RAM address
load_data  in  DATA_W  program/data byte
load_ready  out  1  scheduler accepts byte this cycle
load_end  in  1  host marks end of program
cpu_hlt  in  1  HLT from control sequencer
ram_mode  out  1  RAM input_mode (1 = external load owns RAM)
ram_addr  out  ADDR_W  RAM input_address
ram_data  out  DATA_W  RAM input_program
ram_we  out  1  one-cycle write strobe
cpu_rst  out  1  CPU reset hold, active-high
cpu_run  out  1  CPU enabled
state  out  2  IDLE=0, LOAD=1, RUN=2, DONE=3
words_loaded  out  ADDR_W+1  count of distinct addresses written
written_map  out  16  bit i set once address i written
timeout  out  1  RUN ended by budget, not HLT
err_empty  out  1  load_end seen with address 0 unwritten

Behaviour:
- Reset (async): state=IDLE, load_ready=0, ram_mode=0, ram_addr=0, ram_data=0, ram_we=0, cpu_rst=1, cpu_run=0, words_loaded=0, written_map=0, timeout=0, err_empty=0, run counter=0. Any pending write is dropped.
- Moore outputs from the state register:
  - load_ready=ram_mode=(LOAD)
  - cpu_rst=(IDLE or LOAD)
  - cpu_run=(RUN)
  - DONE: cpu_rst=0, cpu_run=0, so CPU state is frozen for inspection.
- IDLE: load_start=1 -> LOAD, clearing written_map, words_loaded, timeout, err_empty.
- LOAD: a handshake is load_valid & load_ready.
  - Accepted byte at edge N appears on ram_addr/ram_data with ram_we=1 for exactly the cycle after edge N (1-cycle latency). Otherwise ram_we=0 and addr/data hold.
  - Rewriting an address is allowed: the RAM takes the last value, and words_loaded increments only when that written_map bit was clear (max 16).
- load_end in LOAD:
  - If load_valid is also high, the byte is accepted first.
  - If written_map[0] (including that byte) is set -> RUN, counter=0.
  - Otherwise -> IDLE with err_empty=1.
  - The final ram_we pulse still issues in the next cycle, while ram_mode is already 0. The RAM must latch on ram_we, not on ram_mode.
- RUN: counter increments each cycle.
  - cpu_hlt=1 -> DONE, timeout=0.
  - Else if counter==MAX_CYCLES-1 -> DONE, timeout=1.
  - If both occur in the same cycle, HLT wins.
  - load_start and load_valid are ignored.
- DONE: load_start -> LOAD (same clears as from IDLE). cpu_hlt is ignored.
- Reset mid-LOAD or mid-RUN returns to IDLE immediately; the CPU is held in reset.

Test Plan:
- Load 9h=09, Ah=0D, 0h=79, 1h=30, 2h=7A, 3h=10, 4h=40, then load_end -> seven ram_we pulses, each 1 cycle after its handshake with matching addr/data; words_loaded=7; written_map=0x061F; state=RUN, cpu_rst=0, cpu_run=1.
- Write 3h=10 then 3h=11 -> words_loaded=1, last ram_data=11; load_valid with load_end on 0h=79 -> write pulse occurs, RUN entered.
- Load only 9h=09, then load_end -> state=IDLE, err_empty=1, cpu_rst stays 1.
- RUN with cpu_hlt asserted at cycle 30 -> DONE, timeout=0, cpu_run=0. Then load_start -> LOAD with map/count cleared.
- MAX_CYCLES=20, cpu_hlt never asserted -> DONE exactly 20 cycles after RUN entry, timeout=1. Repeat with cpu_hlt on cycle 19 -> timeout=0.
- Assert reset between edges mid-LOAD with a handshake just accepted -> outputs go to reset values without waiting for clk; no ram_we pulse follows.

Source files
------------

// File: rtl/ram_load_scheduler.sv
// Program RAM load-port owner: accepts host bytes, writes the 16x8 RAM,
// then releases the CPU to run until HLT or the cycle budget expires.
module ram_load_scheduler #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int MAX_CYCLES = 255,
    parameter int CNT_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_start,
    input  logic                load_valid,
    input  logic [ADDR_W-1:0]   load_addr,
    input  logic [DATA_W-1:0]   load_data,
    output logic                load_ready,
    input  logic                load_end,
    input  logic                cpu_hlt,
    output logic                ram_mode,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   ram_data,
    output logic                ram_we,
    output logic                cpu_rst,
    output logic                cpu_run,
    output logic [1:0]          state,
    output logic [ADDR_W:0]     words_loaded,
    output logic [(1<<ADDR_W)-1:0] written_map,
    output logic                timeout,
    output logic                err_empty
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   WORD_ONE = (ADDR_W+1)'(1);
    localparam logic [DEPTH-1:0]  MAP_ONE  = DEPTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DEPTH-1:0]    map_q, map_d;
    logic [ADDR_W:0]     words_q, words_d;
    logic                timeout_q, timeout_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                hs;

    assign hs = load_valid && (state_q == S_LOAD);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            map_q     <= '0;
            words_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            map_q     <= map_d;
            words_q   <= words_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        map_d     = map_q;
        words_d   = words_q;
        timeout_d = timeout_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (load_start) begin
                    state_d   = S_LOAD;
                    map_d     = '0;
                    words_d   = '0;
                    timeout_d = 1'b0;
                    err_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (hs) begin
                    we_d   = 1'b1;
                    addr_d = load_addr;
                    data_d = load_data;
                    map_d  = map_q | (MAP_ONE << load_addr);
                    if (!map_q[load_addr])
                        words_d = words_q + WORD_ONE;
                end
                // map_d already includes a byte accepted alongside load_end
                if (load_end) begin
                    if (map_d[0]) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cpu_hlt) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        load_ready   = (state_q == S_LOAD);
        ram_mode     = (state_q == S_LOAD);
        cpu_rst      = (state_q == S_IDLE) || (state_q == S_LOAD);
        cpu_run      = (state_q == S_RUN);
        state        = state_q;
        ram_we       = we_q;
        ram_addr     = addr_q;
        ram_data     = data_q;
        words_loaded = words_q;
        written_map  = map_q;
        timeout      = timeout_q;
        err_empty    = err_q;
    end

endmodule

// File: tb/tb_ram_load_scheduler.sv
// Directed bench for ram_load_scheduler: load, rewrite, empty-load error,
// HLT stop, budget timeout and asynchronous reset during loading.
module tb_ram_load_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start, load_valid, load_end, cpu_hlt;
    logic [3:0]  load_addr;
    logic [7:0]  load_data;

    logic        load_ready, ram_mode, ram_we, cpu_rst, cpu_run;
    logic [3:0]  ram_addr;
    logic [7:0]  ram_data;
    logic [1:0]  state;
    logic [4:0]  words_loaded;
    logic [15:0] written_map;
    logic        timeout, err_empty;

    logic        t_load_ready, t_ram_mode, t_ram_we, t_cpu_rst, t_cpu_run;
    logic [3:0]  t_ram_addr;
    logic [7:0]  t_ram_data;
    logic [1:0]  t_state;
    logic [4:0]  t_words;
    logic [15:0] t_map;
    logic        t_timeout, t_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ram_load_scheduler u_dut (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data),
        .load_ready(load_ready), .load_end(load_end),
        .cpu_hlt(cpu_hlt), .ram_mode(ram_mode),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .ram_we(ram_we), .cpu_rst(cpu_rst), .cpu_run(cpu_run),
        .state(state), .words_loaded(words_loaded),
        .written_map(written_map), .timeout(timeout),
        .err_empty(err_empty)
    );

    ram_load_scheduler #(.MAX_CYCLES(20)) u_dut20 (
        .clk(clk), .reset(reset),
        .load_start(load_start), .load_valid(load_valid),
        .load_addr(load_addr), .load_data(load_data),
        .load_ready(t_load_ready), .load_end(load_end),
        .cpu_hlt(cpu_hlt), .ram_mode(t_ram_mode),
        .ram_addr(t_ram_addr), .ram_data(t_ram_data),
        .ram_we(t_ram_we), .cpu_rst(t_cpu_rst), .cpu_run(t_cpu_run),
        .state(t_state), .words_loaded(t_words),
        .written_map(t_map), .timeout(t_timeout),
        .err_empty(t_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_start = 1'b0;
        load_valid = 1'b0;
        load_end   = 1'b0;
        cpu_hlt    = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        load_valid = 1'b1;
        load_addr  = a;
        load_data  = d;
        tick();
        load_valid = 1'b0;
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, a);
        chk("wr_data", ram_data, d);
        tick();
        chk("wr_we_off", ram_we, 0);
        chk("wr_hold", {ram_addr, ram_data}, {a, d});
    endtask

    task automatic finish_load();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("rst_state", state, 0);
        chk("rst_cpu", {cpu_rst, cpu_run}, 2'b10);
        chk("rst_port", {load_ready, ram_mode, ram_we}, 0);
        chk("rst_ram", {ram_addr, ram_data}, 0);
        chk("rst_cnt", {words_loaded, written_map}, 0);
        chk("rst_flags", {timeout, err_empty}, 0);

        // Full program load
        start();
        chk("ld_state", state, 1);
        chk("ld_ports", {load_ready, ram_mode, cpu_rst, cpu_run}, 4'b1110);
        wr(4'h9, 8'h09);
        wr(4'hA, 8'h0D);
        wr(4'h0, 8'h79);
        wr(4'h1, 8'h30);
        wr(4'h2, 8'h7A);
        wr(4'h3, 8'h10);
        wr(4'h4, 8'h40);
        finish_load();
        chk("p1_words", words_loaded, 7);
        chk("p1_map", written_map, 16'h061F);
        chk("p1_state", state, 2);
        chk("p1_cpu", {cpu_rst, cpu_run}, 2'b01);
        chk("p1_mode", {ram_mode, load_ready, ram_we}, 0);

        // Rewrite and byte accepted with load_end
        do_reset();
        start();
        wr(4'h3, 8'h10);
        wr(4'h3, 8'h11);
        chk("rw_words", words_loaded, 1);
        load_valid = 1'b1;
        load_end   = 1'b1;
        load_addr  = 4'h0;
        load_data  = 8'h79;
        tick();
        load_valid = 1'b0;
        load_end   = 1'b0;
        chk("le_we", ram_we, 1);
        chk("le_ram", {ram_addr, ram_data}, {4'h0, 8'h79});
        chk("le_mode", ram_mode, 0);
        chk("le_state", state, 2);
        chk("le_words", words_loaded, 2);
        chk("le_map", written_map, 16'h0009);
        tick();
        chk("le_we_off", ram_we, 0);

        // Address 0 never written
        do_reset();
        start();
        wr(4'h9, 8'h09);
        finish_load();
        chk("em_state", state, 0);
        chk("em_err", err_empty, 1);
        chk("em_cpu", {cpu_rst, cpu_run}, 2'b10);

        // HLT on the 30th RUN cycle
        do_reset();
        start();
        wr(4'h0, 8'h79);
        finish_load();
        for (int i = 0; i < 29; i++) tick();
        chk("h30_run", state, 2);
        cpu_hlt = 1'b1;
        tick();
        cpu_hlt = 1'b0;
        chk("h30_state", state, 3);
        chk("h30_to", timeout, 0);
        chk("h30_cpu", {cpu_rst, cpu_run}, 2'b00);
        start();
        chk("rl_state", state, 1);
        chk("rl_clear", {words_loaded, written_map}, 0);

        // Budget expiry with MAX_CYCLES=20
        do_reset();
        start();
        wr(4'h0, 8'h79);
        finish_load();
        for (int i = 0; i < 19; i++) tick();
        chk("to_pre", t_state, 2);
        tick();
        chk("to_state", t_state, 3);
        chk("to_flag", t_timeout, 1);
        chk("to_cpu", {t_cpu_rst, t_cpu_run}, 2'b00);
        chk("to_big_run", {state, timeout}, {2'd2, 1'b0});

        // HLT coincides with last budget cycle
        do_reset();
        start();
        wr(4'h0, 8'h79);
        finish_load();
        for (int i = 0; i < 19; i++) tick();
        cpu_hlt = 1'b1;
        tick();
        cpu_hlt = 1'b0;
        chk("hb_state", t_state, 3);
        chk("hb_flag", t_timeout, 0);

        // Async reset right after an accepted byte
        do_reset();
        start();
        load_valid = 1'b1;
        load_addr  = 4'h5;
        load_data  = 8'h55;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_we", ram_we, 0);
        chk("ar_state", state, 0);
        chk("ar_cpu", {cpu_rst, cpu_run, load_ready}, 3'b100);
        chk("ar_clr", {ram_addr, ram_data, written_map}, 0);
        load_valid = 1'b0;
        #1;
        reset = 1'b0;
        tick();
        chk("ar_no_we", ram_we, 0);
        chk("ar_idle", state, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
